// File: rtl/pipe_pkg.sv
// Shared types and field layout for the elastic EX->MEM pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Default EX/MEM payload layout inside the DATA_W field.
  localparam int ALU_RES_MSB = 67;
  localparam int ALU_RES_LSB = 36;
  localparam int VAL_RM_MSB  = 35;
  localparam int VAL_RM_LSB  = 4;
  localparam int DEST_MSB    = 3;
  localparam int DEST_LSB    = 0;

  localparam int WB_EN_BIT    = 2;
  localparam int MEM_R_EN_BIT = 1;
  localparam int MEM_W_EN_BIT = 0;

endpackage

// File: rtl/pipe_slot.sv
// One ctrl+data storage slot; ctrl can be killed independently of the payload.
module pipe_slot #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 68
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (!hold_i) begin
      if (load_i) begin
        ctrl_d = ctrl_i;
        data_d = data_i;
      end
      // Killing the control bits wins over a load; the payload is left alone.
      if (clr_ctrl_i) ctrl_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// Elastic EX->MEM stage register: 2-entry skid buffer with freeze, flush and stall counting.
module exe_mem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 68,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              freeze,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              in_fire, out_fire;
  logic              main_load, main_from_skid, main_clr;
  logic              skid_load, skid_clr, slot_hold;
  logic [CTRL_W-1:0] main_ctrl_in, skid_ctrl;
  logic [DATA_W-1:0] main_data_in, skid_data;

  // in_ready depends only on registered state and freeze, never on out_ready.
  assign in_ready  = (state_q != FULL) && !freeze;
  assign out_valid = (state_q != EMPTY) && !freeze;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!freeze) begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        FULL: if (out_fire) begin
          state_d        = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign slot_hold    = freeze && !flush;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (slot_hold),
    .load_i     (main_load),
    .clr_ctrl_i (main_clr),
    .ctrl_i     (main_ctrl_in),
    .data_i     (main_data_in),
    .ctrl_o     (out_ctrl),
    .data_o     (out_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (slot_hold),
    .load_i     (skid_load),
    .clr_ctrl_i (skid_clr),
    .ctrl_i     (in_ctrl),
    .data_i     (in_data),
    .ctrl_o     (skid_ctrl),
    .data_o     (skid_data)
  );

  // Stalls are counted while frozen too, but not on a flush edge.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign occupancy = 2'(state_q);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
- Parametrised, elastic EX->MEM pipeline register that replaces the fixed flop-only stage register.
- Carries a control field (write-back/memory enables) and a data field (ALU result, Rm value, destination) under a valid/ready handshake.
- A 2-entry skid buffer gives a registered in_ready that never depends on out_ready.
- Adds hazard-unit freeze, branch flush with control-bit kill, occupancy reporting and a saturating stall counter.

Parameters:
- CTRL_W, 3, control bits (WB_EN, MEM_R_EN, MEM_W_EN); forced to 0 on any bubble or flush.
- DATA_W, 68, payload bits (ALU_RES 32 + VAL_RM 32 + DEST 4); never cleared except by rst.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream (EXE) has a valid instruction.
- in_ready  out  1  stage can accept; equals (state!=FULL) && !freeze.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  valid instruction presented to MEM; forced 0 while freeze=1.
- out_ready  in  1  MEM accepts.
- out_ctrl  out  CTRL_W  registered control; 0 whenever the main slot is empty.
- out_data  out  DATA_W  registered payload.
- freeze  in  1  hazard stall: hold all state.
- flush  in  1  kill all held and incoming instructions.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with in_valid && !in_ready.

Behaviour:
- Decided: one clock (clk); rst is synchronous and active-high.
- Reset, at the clk edge with rst=1:
  - main and skid slots empty; ctrl and data registers 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=1 in the following cycle if freeze=0.
- Handshake definitions:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready, evaluated after the freeze mask.
  - Producer holds in_* stable until in_fire; consumer likewise.
- State register (EMPTY/ONE/FULL, equal to occupancy 0/1/2). Transitions take effect only when !flush && !freeze.
- EMPTY:
  - in_fire -> ONE, main<-in.
  - Otherwise stay.
- ONE:
  - in_fire && out_fire -> ONE, main<-in.
  - in_fire && !out_fire -> FULL, skid<-in.
  - !in_fire && out_fire -> EMPTY, main ctrl<-0.
  - Otherwise hold.
- FULL:
  - in_ready=0.
  - out_fire -> ONE, main<-skid, skid ctrl<-0.
  - Otherwise hold.
- Latency:
  - 1 cycle in_fire->out_valid when EMPTY, or when ONE and draining the same cycle.
  - 2 cycles when the entry goes through skid.
  - Order is strictly FIFO.
- Throughput: 1 instruction/cycle sustained when out_ready=1.
- Priority: rst > flush > freeze > normal.
- flush=1 at an edge:
  - State->EMPTY; main and skid ctrl<-0; data registers keep their values.
  - Any in_fire or out_fire in that cycle is discarded: no instruction is lost to MEM, but the one presented is not counted as consumed.
  - in_ready=1 next cycle if freeze=0.
- freeze=1 (without flush):
  - in_ready=0 and out_valid=0 combinationally.
  - All registers hold; stall_cnt still counts.
  - Release resumes with identical contents.
- stall_cnt:
  - +1 on each edge where in_valid && !in_ready && !flush.
  - Saturates at 2^CNT_W-1; cleared only by rst.
- Simultaneous flush+freeze: flush wins.
- rst asserted mid-transfer: the in-flight entry is lost; this is the required behaviour.
- Invariant: out_ctrl!=0 implies occupancy>=1.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic[1:0] {EMPTY=0, ONE=1, FULL=2} pipe_state_t.
  - Localparams for the default EX/MEM field offsets (ALU_RES [67:36], VAL_RM [35:4], DEST [3:0]).
  - CTRL bit indices (WB_EN 2, MEM_R_EN 1, MEM_W_EN 0).
- Sub-module pipe_slot: one ctrl+data register with load, clear-ctrl and hold controls. Instantiate it twice (main, skid); the top holds the FSM and the counter.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0; in_ready=1 after release.
- Streaming: 8 back-to-back in_fire with data=i, ctrl=3'b101, out_ready=1 -> out_data 0..7 on consecutive cycles, 1-cycle latency, stall_cnt=0.
- Backpressure: out_ready=0, push A then B -> occupancy=2, in_ready=0.
  - With in_valid held 3 cycles, stall_cnt=3.
  - Then out_ready=1 -> A, then B in order, occupancy 2->1->0.
- Flush from FULL:
  - flush=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=3'b000, out_data unchanged, in_ready=1.
  - The input offered during the flush cycle never appears.
- Freeze:
  - freeze=1 for 4 cycles at ONE with out_ready=1 -> out_valid=0, in_ready=0, contents unchanged.
  - After release, the same entry is delivered first.
- Saturation and priority:
  - CNT_W=2 with 6 stalled cycles -> stall_cnt=3.
  - flush+freeze asserted together -> flush behaviour.
